// File: rtl/frac_pwm_pkg.sv
// Shared definitions for the fractional PWM block family: FSM encodings and
// default duty-word geometry.
package frac_pwm_pkg;

  localparam int WIDTH_DEF = 17;
  localparam int FSZE_DEF  = 6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_STOP = 2'b10
  } state_e;

endpackage

// File: rtl/frac_pwm_slew.sv
// Clamp of the requested target plus step-limited next value toward it.
// Purely combinational so the frequency-ramp block can reuse it as-is.
module frac_pwm_slew #(
  parameter int WIDTH  = 17,
  parameter int STEP_W = 8
) (
  input  logic signed [WIDTH-1:0] tgt,
  input  logic signed [WIDTH-1:0] lo,
  input  logic signed [WIDTH-1:0] hi,
  input  logic                    use_tgt,
  input  logic signed [WIDTH-1:0] cur,
  input  logic [STEP_W-1:0]       step,
  output logic signed [WIDTH-1:0] eff,
  output logic signed [WIDTH-1:0] nxt
);

  localparam logic [WIDTH:0] ONE = {{WIDTH{1'b0}}, 1'b1};

  logic signed [WIDTH-1:0] clamped;
  logic signed [WIDTH-1:0] step_w;
  logic [WIDTH:0]          diff;
  logic [WIDTH:0]          mag;
  logic [WIDTH:0]          step_x;

  always_comb begin
    // Low bound first, then high, so an inverted window resolves to mf_max.
    clamped = (tgt < lo) ? lo : tgt;
    if (clamped > hi) clamped = hi;
    eff = use_tgt ? clamped : '0;

    // One extra bit keeps the difference of two WIDTH-bit values exact.
    diff   = {eff[WIDTH-1], eff} - {cur[WIDTH-1], cur};
    mag    = diff[WIDTH] ? (~diff + ONE) : diff;
    step_x = {{(WIDTH+1-STEP_W){1'b0}}, step};
    step_w = {{(WIDTH-STEP_W){1'b0}}, step};

    if (step == '0 || mag <= step_x) nxt = eff;
    else if (diff[WIDTH])            nxt = cur - step_w;
    else                             nxt = cur + step_w;
  end

endmodule

// File: rtl/frac_pwm_ramp_ctrl.sv
// Setpoint sequencer for the fractional PWM: target handshake, per-period
// slew of mf_out and a soft-start/soft-stop FSM that gates the PWM.
module frac_pwm_ramp_ctrl
  import frac_pwm_pkg::*;
#(
  parameter int WIDTH  = WIDTH_DEF,
  parameter int FSZE   = FSZE_DEF,
  parameter int STEP_W = 8
) (
  input  logic                    sys_clk,
  input  logic                    sync_rst_n,
  input  logic                    period_tick,
  input  logic                    en,
  input  logic                    tgt_valid,
  output logic                    tgt_ready,
  input  logic signed [WIDTH-1:0] tgt_mf,
  input  logic [STEP_W-1:0]       step,
  input  logic signed [WIDTH-1:0] mf_min,
  input  logic signed [WIDTH-1:0] mf_max,
  output logic signed [WIDTH-1:0] mf_out,
  output logic                    pwm_en,
  output logic                    busy,
  output logic                    at_target,
  output logic [1:0]              state
);

  if (FSZE >= WIDTH) begin : g_bad_fsze
    $error("FSZE must leave at least one integer bit");
  end

  state_e                  state_q, state_d;
  logic signed [WIDTH-1:0] tgt_reg_q, tgt_reg_d;
  logic signed [WIDTH-1:0] mf_out_q, mf_out_d;
  logic                    pwm_en_q, pwm_en_d;
  logic                    tgt_ready_q, tgt_ready_d;
  logic                    busy_q, busy_d;
  logic                    at_target_q, at_target_d;
  logic signed [WIDTH-1:0] eff, mf_nxt;

  frac_pwm_slew #(.WIDTH(WIDTH), .STEP_W(STEP_W)) u_slew (
    .tgt     (tgt_reg_q),
    .lo      (mf_min),
    .hi      (mf_max),
    .use_tgt (state_q == ST_RUN),
    .cur     (mf_out_q),
    .step    (step),
    .eff     (eff),
    .nxt     (mf_nxt)
  );

  always_comb begin
    state_d     = state_q;
    tgt_reg_d   = tgt_reg_q;
    mf_out_d    = mf_out_q;
    pwm_en_d    = pwm_en_q;
    tgt_ready_d = 1'b1;
    busy_d      = (mf_out_q != eff) || (state_q == ST_STOP);
    at_target_d = (mf_out_q == eff);

    // The slew sees the pre-transfer target; a new one applies next tick.
    if (tgt_valid && tgt_ready_q) tgt_reg_d = tgt_mf;
    if (period_tick) mf_out_d = mf_nxt;

    case (state_q)
      ST_IDLE: begin
        mf_out_d = '0;
        pwm_en_d = en;
        if (en) state_d = ST_RUN;
      end
      ST_RUN: begin
        pwm_en_d = 1'b1;
        if (!en) state_d = ST_STOP;
      end
      ST_STOP: begin
        if (en) state_d = ST_RUN;
        else if (period_tick && mf_out_q == '0) begin
          state_d  = ST_IDLE;
          pwm_en_d = 1'b0;
        end
      end
      default: begin
        state_d  = ST_IDLE;
        mf_out_d = '0;
        pwm_en_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge sys_clk or negedge sync_rst_n) begin
    if (!sync_rst_n) begin
      state_q     <= ST_IDLE;
      tgt_reg_q   <= '0;
      mf_out_q    <= '0;
      pwm_en_q    <= 1'b0;
      tgt_ready_q <= 1'b0;
      busy_q      <= 1'b0;
      at_target_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      tgt_reg_q   <= tgt_reg_d;
      mf_out_q    <= mf_out_d;
      pwm_en_q    <= pwm_en_d;
      tgt_ready_q <= tgt_ready_d;
      busy_q      <= busy_d;
      at_target_q <= at_target_d;
    end
  end

  assign state     = state_q;
  assign mf_out    = mf_out_q;
  assign pwm_en    = pwm_en_q;
  assign tgt_ready = tgt_ready_q;
  assign busy      = busy_q;
  assign at_target = at_target_q;

endmodule

// File: doc/frac_pwm_ramp_ctrl.md
# frac_pwm_ramp_ctrl

Setpoint sequencer for the fractional PWM generator. It accepts target duty words over a valid/ready handshake and clamps them to a configured window. It slews its `mf_out` output toward the target by a bounded step once per PWM period, and runs a soft-start/soft-stop state machine that gates the PWM. It sits between the host register interface and the PWM's signed fractional input `mf`.

## Interface
- `WIDTH`, 17: width of the signed fixed-point duty word. The low `FSZE` bits are fraction.
- `FSZE`, 6: number of fractional bits. Must match the PWM instance.
- `STEP_W`, 8: width of the slew-step input.

- `sys_clk` in 1: single clock. All state changes on the rising edge.
- `sync_rst_n` in 1: reset, asynchronous assert, active-low.
- `period_tick` in 1: one-cycle pulse at each PWM period boundary.
- `en` in 1: level run request.
- `tgt_valid` in 1: new target offered.
- `tgt_ready` out 1: target can be accepted.
- `tgt_mf` in WIDTH signed: target duty word.
- `step` in STEP_W unsigned: maximum change per period, in fractional LSBs. A value of 0 means jump to target.
- `mf_min`, `mf_max` in WIDTH signed: clamp window. Quasi-static.
- `mf_out` out WIDTH signed: duty word driven to the PWM `mf` input.
- `pwm_en` out 1: PWM output gate.
- `busy` out 1: `mf_out` differs from the effective target, or state is STOP.
- `at_target` out 1: `mf_out` equals the effective target.
- `state` out 2: current FSM state, for debug.

## Operation
- States: IDLE=00, RUN=01, STOP=10. Encoding 11 is illegal and recovers to IDLE on the next clock.
- IDLE:
  - `mf_out`=0, `pwm_en`=0.
  - `en`=1 → RUN, with `pwm_en`=1 registered on the same edge.
- RUN:
  - Effective target `eff` = clamp(`tgt_reg`). Apply the low bound first, then the high bound; if `mf_min` > `mf_max`, `mf_max` wins.
  - `en`=0 → STOP.
- STOP:
  - `eff` = 0.
  - `en`=1 → RUN (target ramp resumes from the current `mf_out`).
  - On a `period_tick` where `mf_out`==0 at the start of the tick: → IDLE, `pwm_en`=0.
- Slew, only on a cycle with `period_tick`=1:
  - d = `eff` − `mf_out`, computed at WIDTH+1 bits. No wrap is possible.
  - If `step`==0 or |d| ≤ `step` (zero-extended): `mf_out` ← `eff`.
  - Otherwise: `mf_out` ← `mf_out` ± `step`, toward `eff`.
- Handshake:
  - Transfer occurs when `tgt_valid` & `tgt_ready`. `tgt_reg` ← `tgt_mf` on that edge.
  - `tgt_ready` is high in all states, from the first clock after reset release.
  - Targets are accepted in IDLE and STOP too; they take effect on the next RUN.
- Simultaneous events:
  - Transfer and `period_tick` on the same cycle: the slew uses the old `tgt_reg`; the new target applies from the next tick.
  - `en` change and `period_tick` on the same cycle: the slew uses the `eff` of the current state; the state changes on the same edge.
- Reset, at any time including mid-ramp:
  - `mf_out`=0, `tgt_reg`=0, state=IDLE, `pwm_en`=0, `tgt_ready`=0, `busy`=0, `at_target`=1.
  - There is no ramp-down on reset.

## Timing
- `mf_out` changes only on the edge that samples `period_tick`=1. It is valid from the next cycle and stable until the next tick.
- The PWM registers `mf` through a 3-stage pipeline. `period_tick` must therefore precede the PWM reload (period count 0) by ≥4 `sys_clk` cycles. The top level derives it from the period counter value 4.
- Latency:
  - Target transfer → first `mf_out` movement: the first `period_tick` strictly after the transfer edge.
  - `en` rise → `pwm_en`=1: 1 cycle.
  - STOP → IDLE: the tick after `mf_out` reaches 0.
- `busy` and `at_target` are registered, updated one cycle after the `mf_out`/state change.

## Structure
- Shared package `frac_pwm_pkg`:
  - state encodings `ST_IDLE`, `ST_RUN`, `ST_STOP`;
  - default `WIDTH`/`FSZE` constants, shared with `frac_pwm`.
- Sub-module `frac_pwm_slew`: combinational clamp plus step-limited next-value computation (`eff`, `mf_out`, `step` → next). Reused by the planned frequency-ramp block.
- The FSM, target register and handshake live in the top module.

## Test plan
- Reset, `en`=1, transfer `tgt_mf`=640 (10.0), `step`=64, window [−4096, 4095] → `mf_out` reads 64, 128, … 640 over 10 ticks; `at_target`=1 one cycle after the 10th tick.
- Transfer `tgt_mf`=5000 with `mf_max`=4095, `step`=0 → `mf_out`=4095 after one tick; `busy`=0.
- `en`=0 while at 640, `step`=100 → STOP; `mf_out` 540, 440, … 40, 0; `pwm_en` drops on the tick after 0; state=IDLE.
- `en` re-asserted at `mf_out`=240 during STOP → state RUN on the next edge; ramp back up to 640.
- Transfer and `period_tick` on the same cycle (old target 640 reached, new target −64, `step`=0) → `mf_out` holds 640 on that tick and becomes −64 on the next tick.
- `sync_rst_n` pulsed low mid-ramp at `mf_out`=320 → all outputs at reset values immediately (asynchronously); `tgt_ready` returns high 1 cycle after release.
